// File: rtl/always_block_pkg.sv
// always_block_pkg: shared constants and helpers for the always_block slice.
//   CNT_W_DEFAULT : default width of the high-cycle counter
//   all_ones(w)   : all-ones value of width w (1..32), returned in 32 bits
package always_block_pkg;

    localparam int CNT_W_DEFAULT = 8;

    // Computed in 64 bits so w = 32 does not overflow the shift.
    function automatic logic [31:0] all_ones(input int w);
        logic [63:0] v;
        v = (64'd1 << w) - 64'd1;
        return v[31:0];
    endfunction

endpackage

// File: rtl/always_block_sat_counter.sv
// sat_counter: generic saturating up-counter.
//   clk   : clock, rising edge
//   clr_n : synchronous active-low clear (priority over counting)
//   en    : count enable, +1 per enabled edge until all-ones
//   count : current count, holds at all-ones, never wraps
//   sat   : registered flag, set on the same edge count reaches all-ones
module sat_counter
    import always_block_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         sat
);

    localparam logic [W-1:0] MAX = W'(all_ones(W));

    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (en && (count != MAX))
            count_next = count + W'(1);
    end

    // sat compares the next value so it rises together with count.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            sat   <= (count_next == MAX);
        end
    end

endmodule

// File: rtl/always_block.sv
// always_block: two-input AND with registered copy, rising-edge pulse and
// saturating high-cycle counter.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   a, b     : operands
//   c        : combinational a & b (independent of clock and reset)
//   c_q      : c registered once
//   c_rise   : one-cycle pulse when c_q goes 0->1
//   hi_count : cycles c_q has been 1, saturating at all-ones
//   hi_sat   : hi_count == all-ones (registered)
// Build option: define ALWAYS_BLOCK_STATS_EN to include c_rise, hi_count and
// hi_sat; otherwise they are tied to 0 and their registers are absent.
module always_block
    import always_block_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             c_q,
    output logic             c_rise,
    output logic [CNT_W-1:0] hi_count,
    output logic             hi_sat
);

    assign c = a & b;

    always_ff @(posedge clk) begin
        if (!rst_n) c_q <= 1'b0;
        else        c_q <= c;
    end

`ifdef ALWAYS_BLOCK_STATS_EN
    logic c_q_d;

    // c_q_d clears with reset, so c already high at release gives a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q_d  <= 1'b0;
            c_rise <= 1'b0;
        end else begin
            c_q_d  <= c_q;
            c_rise <= c_q & ~c_q_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_hi_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (c_q),
        .count (hi_count),
        .sat   (hi_sat)
    );
`else
    assign c_rise   = 1'b0;
    assign hi_count = '0;
    assign hi_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_always_block.sv
module tb_always_block;

    logic clk = 1'b0;
    logic rst_n, a, b;
    always #5 clk = ~clk;

    logic       c8, cq8, rise8, sat8;
    logic [7:0] cnt8;
    logic       c3, cq3, rise3, sat3;
    logic [2:0] cnt3;

    always_block #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c8), .c_q(cq8),
        .c_rise(rise8), .hi_count(cnt8), .hi_sat(sat8)
    );
    always_block #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c3), .c_q(cq3),
        .c_rise(rise3), .hi_count(cnt3), .hi_sat(sat3)
    );

    int errs = 0;
    int chks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: c_q is last sampled c; pulse when c_q was 1 after the
    // previous edge and 0 the edge before; count = edges since reset with
    // c_q high, clipped at the width's maximum.
    bit m_cq1, m_cq2, m_rise;
    int m_cnt;
    int rise_seen;

    task automatic tick(input logic ra, input logic rb, input logic rr);
        int e_cnt8, e_cnt3, e_rise;
        a = ra; b = rb; rst_n = rr;
        @(posedge clk);
        if (!rr) begin
            m_cq1 = 0; m_cq2 = 0; m_rise = 0; m_cnt = 0;
        end else begin
            m_rise = m_cq1 && !m_cq2;
            m_cnt  = m_cnt + int'(m_cq1);
            m_cq2  = m_cq1;
            m_cq1  = ra & rb;
        end
        @(negedge clk);
`ifdef ALWAYS_BLOCK_STATS_EN
        e_rise = int'(m_rise);
        e_cnt8 = (m_cnt > 255) ? 255 : m_cnt;
        e_cnt3 = (m_cnt > 7) ? 7 : m_cnt;
`else
        e_rise = 0; e_cnt8 = 0; e_cnt3 = 0;
`endif
        chk("c8", c8, ra & rb);
        chk("c3", c3, ra & rb);
        chk("cq8", cq8, m_cq1);
        chk("cq3", cq3, m_cq1);
        chk("rise8", rise8, e_rise);
        chk("rise3", rise3, e_rise);
        chk("cnt8", cnt8, e_cnt8);
        chk("cnt3", cnt3, e_cnt3);
        chk("sat8", sat8, (e_cnt8 == 255));
        chk("sat3", sat3, (e_cnt3 == 7));
        if (rise8 === 1'b1) rise_seen++;
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0;

        // Truth table, no clock dependency.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            a = v[1]; b = v[0];
            #1;
            chk("tt_c8", c8, (i == 3));
            chk("tt_c3", c3, (i == 3));
            #4;
        end

        // Reset with 11 held: c follows inputs, everything else zero.
        @(negedge clk);
        tick(1, 1, 0);
        tick(1, 1, 0);

        // Latency then counting: 10 cycles of 11, then 00.
        tick(0, 0, 1);
        tick(0, 0, 1);
        for (int i = 0; i < 10; i++) tick(1, 1, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 1);
`ifdef ALWAYS_BLOCK_STATS_EN
        chk("cnt_hold10", cnt8, 10);
        chk("cnt3_hold7", cnt3, 7);
        chk("sat3_set", sat3, 1);
`else
        chk("cnt_off", cnt8, 0);
        chk("sat_off", sat3, 0);
`endif

        // Second 0->1 transition: exactly one more pulse.
        rise_seen = 0;
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(1, 1, 1);
        tick(0, 0, 1);
        tick(0, 0, 1);
`ifdef ALWAYS_BLOCK_STATS_EN
        chk("one_pulse", rise_seen, 1);
`else
        chk("no_pulse", rise_seen, 0);
`endif

        // Saturation from clean state, then reset while saturated.
        tick(0, 0, 0);
        for (int i = 0; i < 12; i++) tick(1, 1, 1);
        tick(1, 1, 0);
        // Release with c already high: pulses once.
        for (int i = 0; i < 4; i++) tick(1, 1, 1);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            tick(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 29) != 0));

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
